// File: rtl/alu_mdu_pkg.sv
// Shared ALU control codes and multiply-unit FSM states for the execute stage.
// Imported by the ALU decoder and alu_mdu so each code has a single definition.
package alu_mdu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_MULT = 3'b100,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SIGN = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/alu_mdu_mul_iter.sv
// Unsigned WxW shift-add multiplier core: one iteration per cycle, W cycles after start.
// No backpressure; start is accepted only while idle, flush drops the operation in progress.
module alu_mdu_mul_iter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           flush,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           busy,
  output logic           last,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] count;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;
  logic [W:0]    upper;

  // Carry out of the upper-half add is shifted back into the accumulator.
  assign upper = {1'b0, prod[2*W-1:W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign last  = busy & (count == CW'(W-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      count    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod     <= '0;
    end else if (flush) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start && !busy) begin
      busy     <= 1'b1;
      count    <= '0;
      mcand_q  <= mcand;
      mplier_q <= mplier;
      prod     <= '0;
    end else if (busy) begin
      prod     <= {upper, prod[W-1:1]};
      mplier_q <= mplier_q >> 1;
      count    <= count + CW'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU (combinational) plus iterative signed/unsigned multiply into HI/LO.
// A multiply holds stall for 34 cycles (start + 32 iterations + sign fix-up); done pulses after.
import alu_mdu_pkg::*;

module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  input  logic             hassign,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             done
);

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               lt;
  logic               start;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               core_busy;
  logic               core_last;
  logic [2*WIDTH-1:0] core_prod;
  logic [2*WIDTH-1:0] prod_signed;
  mdu_state_e         state;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = hassign ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alucontrol)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = hassign & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = hassign & (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  assign start = valid & (alucontrol == ALU_MULT) & ~flush & (state == ST_IDLE);
  assign stall = start | (state != ST_IDLE);

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign mag_a = (hassign & a[WIDTH-1]) ? -a : a;
  assign mag_b = (hassign & b[WIDTH-1]) ? -b : b;

  alu_mdu_mul_iter #(.W(WIDTH)) u_mul_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .mcand  (mag_a),
    .mplier (mag_b),
    .busy   (core_busy),
    .last   (core_last),
    .prod   (core_prod)
  );

  assign prod_signed = neg ? -core_prod : core_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_MUL;
            neg   <= hassign & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        ST_MUL: begin
          if (flush || !core_busy) state <= ST_IDLE;
          else if (core_last)      state <= ST_SIGN;
        end
        ST_SIGN: begin
          state <= ST_IDLE;
          if (!flush) begin
            {hi, lo} <= prod_signed;
            done     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: ALU vector table, random ALU/multiply vs a plain-arithmetic model,
// and hand sequences for multiply timing, flush and reset mid-multiply.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alucontrol;
  logic        hassign;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        done;

  int checks   = 0;
  int failures = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .flush      (flush),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .hassign    (hassign),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .hi         (hi),
    .lo         (lo),
    .stall      (stall),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic        hs;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } alu_vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        hs;
    logic [31:0] ehi;
    logic [31:0] elo;
  } mul_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference ALU: true mathematical sum/difference decides overflow.
  task automatic model_alu(input logic [31:0] x, input logic [31:0] y, input logic [2:0] c,
                           input logic s, output logic [31:0] r, output logic ov);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint t;
    r  = 32'h0;
    ov = 1'b0;
    case (c)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin r = x + y; t = sx + sy; ov = s && (t != longint'($signed(r))); end
      3'b110: begin r = x - y; t = sx - sy; ov = s && (t != longint'($signed(r))); end
      3'b111: r = s ? {31'b0, sx < sy} : {31'b0, x < y};
      default: r = 32'h0;
    endcase
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] ux;
    logic [63:0] uy;
    longint p;
    if (s) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
  endfunction

  // Issue one multiply, scramble inputs while busy, check stall length, done and HI/LO.
  task automatic do_mult(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic s, input logic [63:0] exp_prod);
    int stalls = 0;
    bit ended  = 0;
    bit early  = 0;
    @(negedge clk);
    a = xa; b = xb; hassign = s; alucontrol = 3'b100; valid = 1'b1;
    #1;
    if (stall) stalls++;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      valid = 1'b0; alucontrol = 3'b000;
      a = $urandom; b = $urandom; hassign = 1'($urandom_range(0, 1));
      #1;
      if (!stall) begin
        ended = 1;
        break;
      end
      if (done) early = 1;
      stalls++;
    end
    chk({tag, "_ended"}, 64'(ended), 64'd1);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'd34);
    chk({tag, "_early_done"}, 64'(early), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hilo"}, {hi, lo}, exp_prod);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  alu_vec_t av[10];
  mul_vec_t mv[6];

  initial begin
    logic [31:0] r;
    logic        ov;
    bit          saw;

    av[0] = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b1, 32'h80000000, 1'b0, 1'b1};
    av[1] = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b0, 32'h80000000, 1'b0, 1'b0};
    av[2] = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 1'b1, 32'h00000001, 1'b0, 1'b0};
    av[3] = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 1'b0, 32'h00000000, 1'b1, 1'b0};
    av[4] = '{32'h00000005, 32'h00000005, 3'b110, 1'b1, 32'h00000000, 1'b1, 1'b0};
    av[5] = '{32'h80000000, 32'h00000001, 3'b110, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
    av[6] = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 1'b0, 32'h00F000F0, 1'b0, 1'b0};
    av[7] = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b0};
    av[8] = '{32'h12345678, 32'h00000009, 3'b011, 1'b1, 32'h00000000, 1'b1, 1'b0};
    av[9] = '{32'h00000003, 32'h00000004, 3'b100, 1'b1, 32'h00000000, 1'b1, 1'b0};

    mv[0] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    mv[1] = '{32'hFFFFFFFE, 32'h00000003, 1'b0, 32'h00000002, 32'hFFFFFFFA};
    mv[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    mv[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h80000000};
    mv[4] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 32'h00000000, 32'h00000000};
    mv[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};

    rst = 1'b0; valid = 1'b0; flush = 1'b0;
    a = '0; b = '0; alucontrol = 3'b000; hassign = 1'b0;
    #1;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (av[i]) begin
      @(negedge clk);
      a = av[i].a; b = av[i].b; alucontrol = av[i].ctrl; hassign = av[i].hs;
      #1;
      chk($sformatf("vec%0d_result", i), 64'(result), 64'(av[i].res));
      chk($sformatf("vec%0d_zero", i), 64'(zero), 64'(av[i].z));
      chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(av[i].ov));
    end
    chk("vec_mult_no_stall", 64'(stall), 64'd0);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; hassign = 1'($urandom_range(0, 1));
      alucontrol = 3'($urandom_range(0, 7));
      if (i % 5 == 0) b = a;
      #1;
      model_alu(a, b, alucontrol, hassign, r, ov);
      chk($sformatf("rand%0d_result", i), 64'(result), 64'(r));
      chk($sformatf("rand%0d_zero", i), 64'(zero), 64'(r == 32'h0));
      chk($sformatf("rand%0d_overflow", i), 64'(overflow), 64'(ov));
    end

    foreach (mv[i])
      do_mult($sformatf("mult%0d", i), mv[i].a, mv[i].b, mv[i].hs, {mv[i].ehi, mv[i].elo});

    for (int i = 0; i < 6; i++) begin
      logic [31:0] xa = $urandom;
      logic [31:0] xb = $urandom;
      logic        s  = 1'($urandom_range(0, 1));
      if (i == 0) xa = 32'h80000000;
      do_mult($sformatf("rmult%0d", i), xa, xb, s, model_prod(xa, xb, s));
    end

    // Flush at MUL cycle 10: prior HI/LO from a known multiply must survive.
    do_mult("pre_flush", 32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFF_FFFFFFFA);
    @(negedge clk);
    a = 32'h7; b = 32'h9; alucontrol = 3'b100; hassign = 1'b0; valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = 1'b0; alucontrol = 3'b000;
    end
    #1;
    chk("flush_pre_stall", 64'(stall), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done || stall) saw = 1;
    end
    chk("flush_no_done", 64'(saw), 64'd0);
    chk("flush_hilo_later", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

    @(negedge clk);
    a = 32'h5; b = 32'h6; alucontrol = 3'b100; valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start_stall", 64'(stall), 64'd0);
    @(negedge clk);
    valid = 1'b0; flush = 1'b0; alucontrol = 3'b000;
    #1;
    chk("flush_start_after", 64'(stall), 64'd0);

    @(negedge clk);
    a = 32'h00010001; b = 32'h00020002; alucontrol = 3'b100; hassign = 1'b0; valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      valid = 1'b0; alucontrol = 3'b000;
    end
    rst = 1'b0;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_mult("post_rst", 32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
